// File: rtl/discharge_pkg.sv
// Shared definitions for the discharge-control path: state encodings,
// current word type and default timing/limit constants.
package discharge_pkg;

    localparam int CUR_W = 16;
    localparam int CNT_W = 16;

    typedef logic [CUR_W-1:0] cur_t;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_HS_ON    = 3'd1,
        ST_DT_TO_LS = 3'd2,
        ST_LS_ON    = 3'd3,
        ST_DT_TO_HS = 3'd4,
        ST_FAULT    = 3'd5
    } state_t;

    localparam int   DEF_DEADTIME = 4;
    localparam int   DEF_MIN_ON   = 10;
    localparam int   DEF_MIN_OFF  = 10;
    localparam int   DEF_MAX_ON   = 200;
    localparam cur_t DEF_I_LIMIT  = 16'hF000;

endpackage

// File: rtl/hyst_threshold.sv
// Registered hysteresis window around the current setpoint; the upper edge
// saturates at full scale and the lower edge clamps at zero.
module hyst_threshold
    import discharge_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic [CUR_W-1:0] i_set,
    input  logic [CUR_W-1:0] hyst_band,
    output logic [CUR_W-1:0] upper,
    output logic [CUR_W-1:0] lower
);

    logic [CUR_W:0] sum;

    assign sum = {1'b0, i_set} + {1'b0, hyst_band};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            upper <= '0;
            lower <= '0;
        end else begin
            upper <= sum[CUR_W] ? {CUR_W{1'b1}} : sum[CUR_W-1:0];
            lower <= (hyst_band > i_set) ? '0 : i_set - hyst_band;
        end
    end

endmodule

// File: rtl/buck_hyst_current_ctrl.sv
// Hysteretic current-mode buck controller: complementary gates with dead
// time, min on/off, max on-time and a sticky over-current trip.
module buck_hyst_current_ctrl
    import discharge_pkg::*;
#(
    parameter int               DEADTIME = DEF_DEADTIME,
    parameter int               MIN_ON   = DEF_MIN_ON,
    parameter int               MIN_OFF  = DEF_MIN_OFF,
    parameter int               MAX_ON   = DEF_MAX_ON,
    parameter logic [CUR_W-1:0] I_LIMIT  = DEF_I_LIMIT
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             enable,
    input  logic [CUR_W-1:0] i_set,
    input  logic [CUR_W-1:0] hyst_band,
    input  logic [CUR_W-1:0] i_meas,
    input  logic             i_meas_valid,
    input  logic             fault_clr,
    output logic             gate_hs,
    output logic             gate_ls,
    output logic             fault,
    output logic [2:0]       state_o,
    output logic [31:0]      hs_pulse_cnt
);

    localparam logic [CNT_W-1:0] DT_LAST     = CNT_W'(DEADTIME - 1);
    localparam logic [CNT_W-1:0] MIN_ON_M1   = CNT_W'(MIN_ON - 1);
    localparam logic [CNT_W-1:0] MIN_OFF_M1  = CNT_W'(MIN_OFF - 1);
    localparam logic [CNT_W-1:0] MAX_ON_LAST = CNT_W'(MAX_ON - 1);

    state_t           state, next_state;
    logic [CNT_W-1:0] cnt;
    logic [CUR_W-1:0] i_meas_q, upper, lower;
    logic             over_i, run_ok;

    // i_meas_valid is a one-cycle strobe with no back-pressure: i_meas is
    // captured (and checked for over-current) only in cycles where it is high.
    assign over_i  = i_meas_valid && (i_meas > I_LIMIT);
    assign run_ok  = enable && (i_set != '0);
    assign state_o = state;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) i_meas_q <= '0;
        else if (i_meas_valid) i_meas_q <= i_meas;
    end

    hyst_threshold u_thr (
        .clk       (clk),
        .rst       (rst),
        .i_set     (i_set),
        .hyst_band (hyst_band),
        .upper     (upper),
        .lower     (lower)
    );

    always_comb begin
        next_state = state;
        if (state != ST_FAULT && over_i) begin
            next_state = ST_FAULT;
        end else if (state != ST_FAULT && !run_ok) begin
            next_state = ST_IDLE;
        end else begin
            case (state)
                ST_IDLE:     if (i_meas_q < upper) next_state = ST_HS_ON;
                ST_HS_ON:    if ((cnt >= MIN_ON_M1 && i_meas_q >= upper) || cnt == MAX_ON_LAST)
                                 next_state = ST_DT_TO_LS;
                ST_DT_TO_LS: if (cnt == DT_LAST) next_state = ST_LS_ON;
                ST_LS_ON:    if (cnt >= MIN_OFF_M1 && i_meas_q <= lower) next_state = ST_DT_TO_HS;
                ST_DT_TO_HS: if (cnt == DT_LAST) next_state = ST_HS_ON;
                ST_FAULT:    if (fault_clr && !enable && !over_i) next_state = ST_IDLE;
                default:     next_state = ST_IDLE;
            endcase
        end
    end

    // Gates and fault are loaded from next_state so they change on the same
    // edge as the state register; the counter saturates so LS_ON can last forever.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= ST_IDLE;
            cnt          <= '0;
            gate_hs      <= 1'b0;
            gate_ls      <= 1'b0;
            fault        <= 1'b0;
            hs_pulse_cnt <= '0;
        end else begin
            state   <= next_state;
            gate_hs <= (next_state == ST_HS_ON);
            gate_ls <= (next_state == ST_LS_ON);
            fault   <= (next_state == ST_FAULT);
            if (next_state != state) cnt <= '0;
            else if (cnt != {CNT_W{1'b1}}) cnt <= cnt + CNT_W'(1);
            // A new burst out of IDLE restarts the count with its first pulse.
            if (next_state == ST_HS_ON && state == ST_IDLE) hs_pulse_cnt <= 32'd1;
            else if (next_state == ST_HS_ON && state != ST_HS_ON) hs_pulse_cnt <= hs_pulse_cnt + 32'd1;
        end
    end

endmodule

// File: tb/tb_buck_hyst_current_ctrl.sv
// Directed bench for buck_hyst_current_ctrl: a vector table for regulation,
// disable and fault flows, plus sequences for saturation, MAX_ON and async reset.
module tb_buck_hyst_current_ctrl;
    import discharge_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        enable;
    logic [15:0] i_set, hyst_band, i_meas;
    logic        i_meas_valid, fault_clr;
    logic        gate_hs, gate_ls, fault;
    logic [2:0]  state_o;
    logic [31:0] hs_pulse_cnt;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    buck_hyst_current_ctrl #(
        .DEADTIME (4),
        .MIN_ON   (10),
        .MIN_OFF  (10),
        .MAX_ON   (200),
        .I_LIMIT  (16'hF000)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .enable       (enable),
        .i_set        (i_set),
        .hyst_band    (hyst_band),
        .i_meas       (i_meas),
        .i_meas_valid (i_meas_valid),
        .fault_clr    (fault_clr),
        .gate_hs      (gate_hs),
        .gate_ls      (gate_ls),
        .fault        (fault),
        .state_o      (state_o),
        .hs_pulse_cnt (hs_pulse_cnt)
    );

    typedef struct {
        int          cycles;
        logic        en;
        logic [15:0] set;
        logic [15:0] band;
        logic [15:0] meas;
        logic        mv;
        logic        clr;
        logic [2:0]  st;
        logic        hs;
        logic        ls;
        logic        flt;
        logic [31:0] pulses;
    } vec_t;

    localparam int NV = 23;
    vec_t vt[NV];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        int d;

        // steady regulation 900..1100 around i_set=1000, band=100
        vt[0]  = '{1,  1'b1, 16'd1000, 16'd100, 16'd900,  1'b1, 1'b0, ST_IDLE,     1'b0, 1'b0, 1'b0, 32'd0};
        vt[1]  = '{1,  1'b1, 16'd1000, 16'd100, 16'd900,  1'b0, 1'b0, ST_HS_ON,    1'b1, 1'b0, 1'b0, 32'd1};
        vt[2]  = '{1,  1'b1, 16'd1000, 16'd100, 16'd1100, 1'b1, 1'b0, ST_HS_ON,    1'b1, 1'b0, 1'b0, 32'd1};
        vt[3]  = '{8,  1'b1, 16'd1000, 16'd100, 16'd1100, 1'b0, 1'b0, ST_HS_ON,    1'b1, 1'b0, 1'b0, 32'd1};
        vt[4]  = '{1,  1'b1, 16'd1000, 16'd100, 16'd1100, 1'b0, 1'b0, ST_DT_TO_LS, 1'b0, 1'b0, 1'b0, 32'd1};
        vt[5]  = '{3,  1'b1, 16'd1000, 16'd100, 16'd1100, 1'b0, 1'b0, ST_DT_TO_LS, 1'b0, 1'b0, 1'b0, 32'd1};
        vt[6]  = '{1,  1'b1, 16'd1000, 16'd100, 16'd1100, 1'b0, 1'b0, ST_LS_ON,    1'b0, 1'b1, 1'b0, 32'd1};
        vt[7]  = '{1,  1'b1, 16'd1000, 16'd100, 16'd901,  1'b1, 1'b0, ST_LS_ON,    1'b0, 1'b1, 1'b0, 32'd1};
        vt[8]  = '{12, 1'b1, 16'd1000, 16'd100, 16'd901,  1'b0, 1'b0, ST_LS_ON,    1'b0, 1'b1, 1'b0, 32'd1};
        vt[9]  = '{1,  1'b1, 16'd1000, 16'd100, 16'd900,  1'b1, 1'b0, ST_LS_ON,    1'b0, 1'b1, 1'b0, 32'd1};
        vt[10] = '{1,  1'b1, 16'd1000, 16'd100, 16'd900,  1'b0, 1'b0, ST_DT_TO_HS, 1'b0, 1'b0, 1'b0, 32'd1};
        vt[11] = '{3,  1'b1, 16'd1000, 16'd100, 16'd900,  1'b0, 1'b0, ST_DT_TO_HS, 1'b0, 1'b0, 1'b0, 32'd1};
        vt[12] = '{1,  1'b1, 16'd1000, 16'd100, 16'd900,  1'b0, 1'b0, ST_HS_ON,    1'b1, 1'b0, 1'b0, 32'd2};
        vt[13] = '{1,  1'b1, 16'd1000, 16'd100, 16'd1100, 1'b1, 1'b0, ST_HS_ON,    1'b1, 1'b0, 1'b0, 32'd2};
        vt[14] = '{9,  1'b1, 16'd1000, 16'd100, 16'd1100, 1'b0, 1'b0, ST_DT_TO_LS, 1'b0, 1'b0, 1'b0, 32'd2};
        // disable inside dead time, then re-enable straight into HS_ON
        vt[15] = '{1,  1'b0, 16'd1000, 16'd100, 16'd1100, 1'b0, 1'b0, ST_IDLE,     1'b0, 1'b0, 1'b0, 32'd2};
        vt[16] = '{1,  1'b1, 16'd1000, 16'd100, 16'd900,  1'b1, 1'b0, ST_IDLE,     1'b0, 1'b0, 1'b0, 32'd2};
        vt[17] = '{1,  1'b1, 16'd1000, 16'd100, 16'd900,  1'b0, 1'b0, ST_HS_ON,    1'b1, 1'b0, 1'b0, 32'd1};
        // over-current trip, ignored clear, clear racing a strobe, real clear
        vt[18] = '{1,  1'b1, 16'd1000, 16'd100, 16'hF001, 1'b1, 1'b0, ST_FAULT,    1'b0, 1'b0, 1'b1, 32'd1};
        vt[19] = '{2,  1'b1, 16'd1000, 16'd100, 16'hF001, 1'b0, 1'b1, ST_FAULT,    1'b0, 1'b0, 1'b1, 32'd1};
        vt[20] = '{1,  1'b0, 16'd1000, 16'd100, 16'hF001, 1'b1, 1'b1, ST_FAULT,    1'b0, 1'b0, 1'b1, 32'd1};
        vt[21] = '{1,  1'b0, 16'd1000, 16'd100, 16'hF001, 1'b0, 1'b1, ST_IDLE,     1'b0, 1'b0, 1'b0, 32'd1};
        vt[22] = '{1,  1'b0, 16'd1000, 16'd100, 16'hF001, 1'b0, 1'b0, ST_IDLE,     1'b0, 1'b0, 1'b0, 32'd1};

        // clock/reset
        rst = 1'b1; enable = 1'b0; i_set = '0; hyst_band = '0;
        i_meas = '0; i_meas_valid = 1'b0; fault_clr = 1'b0;
        repeat (2) tick();
        check("reset state", 32'(state_o), 32'(ST_IDLE));
        check("reset gate_hs", 32'(gate_hs), 32'd0);
        check("reset gate_ls", 32'(gate_ls), 32'd0);
        check("reset fault", 32'(fault), 32'd0);
        check("reset hs_pulse_cnt", hs_pulse_cnt, 32'd0);
        rst = 1'b0;
        tick();

        // vector table
        for (int i = 0; i < NV; i++) begin
            enable = vt[i].en; i_set = vt[i].set; hyst_band = vt[i].band;
            i_meas = vt[i].meas; i_meas_valid = vt[i].mv; fault_clr = vt[i].clr;
            for (int c = 0; c < vt[i].cycles; c++) begin
                tick();
                i_meas_valid = 1'b0;
            end
            check($sformatf("v%0d state", i), 32'(state_o), 32'(vt[i].st));
            check($sformatf("v%0d gate_hs", i), 32'(gate_hs), 32'(vt[i].hs));
            check($sformatf("v%0d gate_ls", i), 32'(gate_ls), 32'(vt[i].ls));
            check($sformatf("v%0d fault", i), 32'(fault), 32'(vt[i].flt));
            check($sformatf("v%0d hs_pulse_cnt", i), hs_pulse_cnt, vt[i].pulses);
        end

        // threshold saturation at both ends
        enable = 1'b0; fault_clr = 1'b0; i_meas_valid = 1'b0;
        i_set = 16'hFFF0; hyst_band = 16'h0100;
        tick();
        check("sat upper", 32'(dut.u_thr.upper), 32'h0000FFFF);
        check("sat lower", 32'(dut.u_thr.lower), 32'h0000FEF0);
        i_set = 16'd50; hyst_band = 16'd100;
        tick();
        check("clamp upper", 32'(dut.u_thr.upper), 32'd150);
        check("clamp lower", 32'(dut.u_thr.lower), 32'd0);

        // MAX_ON: sample held at 0 never reaches upper
        i_set = 16'd1000; hyst_band = 16'd100; i_meas = 16'd0; i_meas_valid = 1'b1;
        tick();
        i_meas_valid = 1'b0; enable = 1'b1;
        tick();
        check("max_on entry gate_hs", 32'(gate_hs), 32'd1);
        n = 1;
        while (gate_hs && n < 300) begin
            tick();
            if (gate_hs) n++;
        end
        check("max_on hs cycles", 32'(n), 32'd200);
        check("max_on exit state", 32'(state_o), 32'(ST_DT_TO_LS));
        d = 0;
        while (state_o == 3'(ST_DT_TO_LS) && d < 20) begin
            d++;
            check("dead time gates", 32'({gate_hs, gate_ls}), 32'd0);
            tick();
        end
        check("max_on dead cycles", 32'(d), 32'd4);
        check("max_on ls state", 32'(state_o), 32'(ST_LS_ON));
        check("max_on gate_ls", 32'(gate_ls), 32'd1);

        // async reset between clock edges while in LS_ON
        repeat (3) tick();
        check("pre-reset gate_ls", 32'(gate_ls), 32'd1);
        #2 rst = 1'b1;
        #1;
        check("async rst gate_ls", 32'(gate_ls), 32'd0);
        check("async rst state", 32'(state_o), 32'(ST_IDLE));
        check("async rst hs_pulse_cnt", hs_pulse_cnt, 32'd0);
        check("async rst fault", 32'(fault), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        enable = 1'b0;
        tick();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
